// File: rtl/pow_iter.sv
// Sequential base^exp by LSB-first square-and-multiply; N = max(1, bit length of exp) BUSY cycles, result registered after.
// Accepts only in IDLE (ready_o); result and overflow flag held in DONE until yumi_i, then back to IDLE.
module pow_iter #(
    parameter int width_p     = 32,
    parameter int exp_width_p = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     base_i,
    input  logic [exp_width_p-1:0] exp_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [width_p-1:0]     data_o,
    output logic                   overflow_o,
    output logic                   v_o,
    input  logic                   yumi_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [width_p-1:0]       r_acc;
    logic [width_p-1:0]       r_b;
    logic [exp_width_p-1:0]   r_e;
    logic                     r_b_ovf;
    logic                     r_ovf;
    logic                     r_ready;
    logic                     r_v;

    logic [2*width_p-1:0]     w_acc_prod;
    logic [2*width_p-1:0]     w_b_sq;
    logic [exp_width_p-1:0]   w_e_next;
    logic                     w_acc_hi;
    logic                     w_b_hi;

    assign w_acc_prod = {{width_p{1'b0}}, r_acc} * {{width_p{1'b0}}, r_b};
    assign w_b_sq     = {{width_p{1'b0}}, r_b} * {{width_p{1'b0}}, r_b};
    assign w_e_next   = r_e >> 1;
    assign w_acc_hi   = |w_acc_prod[2*width_p-1:width_p];
    assign w_b_hi     = |w_b_sq[2*width_p-1:width_p];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_b     <= '0;
            r_e     <= '0;
            r_b_ovf <= 1'b0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b1;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (v_i) begin
                        r_acc   <= width_p'(1);
                        r_b     <= base_i;
                        r_e     <= exp_i;
                        r_b_ovf <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A lost squaring only matters once the square is actually multiplied in.
                    if (r_e[0]) begin
                        r_acc <= w_acc_prod[width_p-1:0];
                        r_ovf <= r_ovf | w_acc_hi | r_b_ovf;
                    end
                    r_b     <= w_b_sq[width_p-1:0];
                    r_b_ovf <= r_b_ovf | w_b_hi;
                    r_e     <= w_e_next;
                    if (w_e_next == '0) begin
                        r_v     <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (yumi_i) begin
                        r_v     <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_v     <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign v_o        = r_v;
    assign data_o     = r_acc;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_pow_iter.sv
// Bench for pow_iter: directed vector table, handshake corner sequences and a random sweep vs. an arithmetic model.
module tb_pow_iter;

    logic        clk = 1'b0;
    logic        reset_i;

    logic [31:0] w_base, w_exp, w_data;
    logic        w_v, w_ready, w_ovf, w_vo, w_yumi;
    logic [7:0]  n_base, n_data;
    logic [3:0]  n_exp;
    logic        n_v, n_ready, n_ovf, n_vo, n_yumi;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pow_iter #(.width_p(32), .exp_width_p(32)) u_wide (
        .clk_i(clk), .reset_i(reset_i), .base_i(w_base), .exp_i(w_exp), .v_i(w_v),
        .ready_o(w_ready), .data_o(w_data), .overflow_o(w_ovf), .v_o(w_vo), .yumi_i(w_yumi)
    );

    pow_iter #(.width_p(8), .exp_width_p(4)) u_narrow (
        .clk_i(clk), .reset_i(reset_i), .base_i(n_base), .exp_i(n_exp), .v_i(n_v),
        .ready_o(n_ready), .data_o(n_data), .overflow_o(n_ovf), .v_o(n_vo), .yumi_i(n_yumi)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: exact arithmetic, MSB-first modular power and a direct overflow search.
    function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [63:0] e, input int w);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] r = 64'd1;
        for (int i = 63; i >= 0; i--) begin
            r = (r * r) & mask;
            if (e[i]) r = (r * (b & mask)) & mask;
        end
        return r;
    endfunction

    function automatic bit ref_ovf(input logic [63:0] b, input logic [63:0] e, input int w);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] p = 64'd1;
        if (b < 2) return 1'b0;
        for (logic [63:0] k = 0; k < e; k++) begin
            p = p * b;
            if (p > mask) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int ref_n(input logic [63:0] e);
        int n = 0;
        while (e != 0) begin
            n++;
            e = e >> 1;
        end
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic   m_ready(input bit nr); return nr ? n_ready : w_ready; endfunction
    function automatic logic   m_vo(input bit nr);    return nr ? n_vo : w_vo; endfunction
    function automatic logic   m_ovf(input bit nr);   return nr ? n_ovf : w_ovf; endfunction
    function automatic logic [31:0] m_data(input bit nr);
        return nr ? {24'd0, n_data} : w_data;
    endfunction

    task automatic drive(input bit nr, input logic v, input logic [31:0] b, input logic [31:0] e);
        if (nr) begin
            n_v = v; n_base = b[7:0]; n_exp = e[3:0];
        end else begin
            w_v = v; w_base = b; w_exp = e;
        end
    endtask

    task automatic set_yumi(input bit nr, input logic y);
        if (nr) n_yumi = y; else w_yumi = y;
    endtask

    // One op: accept, count BUSY edges until v_o, optionally stall, consume.
    task automatic run_op(input bit nr, input logic [31:0] b, input logic [31:0] e, input int hold,
                          output logic [31:0] d, output bit ov, output int lat);
        int w = 0;
        while (!m_ready(nr) && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("ready_wait", 64'(m_ready(nr)), 64'd1);
        drive(nr, 1'b1, b, e);
        @(posedge clk); #1;
        drive(nr, 1'b0, $urandom, $urandom);
        lat = 0;
        while (!m_vo(nr) && lat < 80) begin
            @(posedge clk); #1; lat++;
        end
        d  = m_data(nr);
        ov = m_ovf(nr);
        if (!m_vo(nr)) begin
            chk("v_timeout", 64'd0, 64'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_data", 64'(m_data(nr)), 64'(d));
        end
        set_yumi(nr, 1'b1);
        @(posedge clk); #1;
        set_yumi(nr, 1'b0);
        chk("v_drop", 64'(m_vo(nr)), 64'd0);
        chk("ready_back", 64'(m_ready(nr)), 64'd1);
    endtask

    typedef struct {
        bit          nr;
        logic [31:0] b;
        logic [31:0] e;
        logic [31:0] d;
        bit          ov;
        int          n;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] d, b, e;
        bit          ov;
        int          lat, w;

        vecs.push_back('{0, 32'd3,          32'd5,          32'd243,        1'b0, 3});
        vecs.push_back('{0, 32'd2,          32'd31,         32'h8000_0000,  1'b0, 5});
        vecs.push_back('{0, 32'd2,          32'd32,         32'd0,          1'b1, 6});
        vecs.push_back('{0, 32'd0,          32'd0,          32'd1,          1'b0, 1});
        vecs.push_back('{0, 32'd0,          32'd40,         32'd0,          1'b0, 6});
        vecs.push_back('{0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 1});
        vecs.push_back('{0, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b1, 2});
        vecs.push_back('{0, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0, 32});
        vecs.push_back('{0, 32'h0001_0000,  32'd2,          32'd0,          1'b1, 2});
        vecs.push_back('{0, 32'd3,          32'd20,         32'd3486784401, 1'b0, 5});
        vecs.push_back('{0, 32'd7,          32'd0,          32'd1,          1'b0, 1});
        vecs.push_back('{1, 32'd3,          32'd6,          32'hD9,         1'b1, 3});
        vecs.push_back('{1, 32'd2,          32'd7,          32'h80,         1'b0, 3});
        vecs.push_back('{1, 32'd2,          32'd8,          32'h00,         1'b1, 4});
        vecs.push_back('{1, 32'd15,         32'd1,          32'h0F,         1'b0, 1});

        reset_i = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 32'd0, 32'd0);
        w_yumi = 1'b0;
        n_yumi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(w_ready), 64'd1);
        chk("rst_v",     64'(w_vo),    64'd0);
        chk("rst_data",  64'(w_data),  64'd0);
        chk("rst_ovf",   64'(w_ovf),   64'd0);
        chk("rst_n_rdy", 64'(n_ready), 64'd1);
        chk("rst_n_dat", 64'(n_data),  64'd0);
        reset_i = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].nr, vecs[i].b, vecs[i].e, 0, d, ov, lat);
            chk($sformatf("vec%0d_data", i), 64'(d),   64'(vecs[i].d));
            chk($sformatf("vec%0d_ovf", i),  64'(ov),  64'(vecs[i].ov));
            chk($sformatf("vec%0d_lat", i),  64'(lat), 64'(vecs[i].n));
        end

        // Backpressure: result held 10 cycles with v_i high, then a queued 7^2 right after consume.
        drive(0, 1'b1, 32'd3, 32'd5);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'd7, 32'd2);
        w = 0;
        while (!w_vo && w < 80) begin
            @(posedge clk); #1; w++;
        end
        chk("bp_lat", 64'(w), 64'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_data",  64'(w_data),  64'd243);
            chk("bp_ovf",   64'(w_ovf),   64'd0);
            chk("bp_v",     64'(w_vo),    64'd1);
            chk("bp_ready", 64'(w_ready), 64'd0);
        end
        w_yumi = 1'b1;
        @(posedge clk); #1;
        w_yumi = 1'b0;
        chk("bp_idle_rdy", 64'(w_ready), 64'd1);
        chk("bp_idle_v",   64'(w_vo),    64'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0);
        chk("bp_accept2", 64'(w_ready), 64'd0);
        w = 0;
        while (!w_vo && w < 80) begin
            @(posedge clk); #1; w++;
        end
        chk("bp2_lat",  64'(w),      64'd2);
        chk("bp2_data", 64'(w_data), 64'd49);
        w_yumi = 1'b1;
        @(posedge clk); #1;
        w_yumi = 1'b0;

        // Reset in the 4th BUSY cycle of a long op.
        drive(0, 1'b1, 32'd3, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_busy_v", 64'(w_vo), 64'd0);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk("mid_rst_ready", 64'(w_ready), 64'd1);
        chk("mid_rst_v",     64'(w_vo),    64'd0);
        chk("mid_rst_data",  64'(w_data),  64'd0);
        run_op(0, 32'd5, 32'd3, 0, d, ov, lat);
        chk("post_rst_data", 64'(d),  64'd125);
        chk("post_rst_ovf",  64'(ov), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 20);
                1:       b = $urandom;
                2:       b = 32'd1 << $urandom_range(0, 31);
                default: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
            endcase
            e = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op(0, b, e, $urandom_range(0, 2), d, ov, lat);
            chk("rnd_data", 64'(d),   ref_pow(64'(b), 64'(e), 32));
            chk("rnd_ovf",  64'(ov),  64'(ref_ovf(64'(b), 64'(e), 32)));
            chk("rnd_lat",  64'(lat), 64'(ref_n(64'(e))));
        end

        for (int i = 0; i < 300; i++) begin
            b = $urandom_range(0, 255);
            e = $urandom_range(0, 15);
            run_op(1, b, e, $urandom_range(0, 2), d, ov, lat);
            chk("nrw_data", 64'(d),   ref_pow(64'(b), 64'(e), 8));
            chk("nrw_ovf",  64'(ov),  64'(ref_ovf(64'(b), 64'(e), 8)));
            chk("nrw_lat",  64'(lat), 64'(ref_n(64'(e))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pow_iter.md
# pow_iter

Parametrised sequential integer power unit. Computes base^exp with square-and-multiply, one exponent bit per cycle, LSB first. Generalises the fixed 2^exp block to an arbitrary base, configurable operand widths, an early-exit variable latency and a sticky overflow flag. Sits behind a valid/ready input and a valid/yumi output, so it can be driven directly by the trace-replay bench or by an upstream FIFO.

## Interface
- width_p, 32, width of base_i and data_o; all internal products are truncated to this width.
- exp_width_p, 32, width of exp_i.
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- base_i  in  width_p  unsigned base.
- exp_i  in  exp_width_p  unsigned exponent.
- v_i  in  1  input valid.
- ready_o  out  1  input ready; the input transfers on v_i & ready_o.
- data_o  out  width_p  base^exp mod 2^width_p.
- overflow_o  out  1  high when the true result ≥ 2^width_p; valid only while v_o is high.
- v_o  out  1  result valid.
- yumi_i  in  1  consumer takes the result; legal only while v_o is high.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - ready_o=1, v_o=0.
  - On v_i: load acc=1, b=base_i, e=exp_i, b_ovf=0, ovf=0, then go to BUSY.
- BUSY, one iteration per cycle:
  - If e[0]=1: acc ← low(acc*b). Set ovf if the high half of the 2·width_p product is non-zero, or if b_ovf=1.
  - b ← low(b*b). b_ovf ← b_ovf | (high half of b*b non-zero).
  - e ← e>>1.
  - Go to DONE when the shifted e is 0; otherwise stay in BUSY.
  - For exp_i=0, the single BUSY cycle performs no multiply, so acc=1 and ovf=0.
- DONE
  - v_o=1, data_o=acc, overflow_o=ovf.
  - Outputs are held stable until yumi_i, then go to IDLE.
- b_ovf gates ovf only through a multiply that actually uses b. Squaring overflow past the last used exponent bit is not reported.
  - base 0 or 1 never overflows.
  - A non-zero acc times an overflowed b is a true overflow.
- ready_o is high only in IDLE. No input is accepted in DONE, including the yumi cycle.
- yumi_i asserted outside DONE is ignored.
- v_i is ignored outside IDLE; input data need not be held after the handshake.
- Multipliers are combinational, width_p×width_p, with no pipelining inside an iteration.

## Timing
- Reset state: IDLE.
  - ready_o=1, v_o=0, data_o=0, overflow_o=0.
  - acc, b, e and both flags are cleared.
- Reset has priority in every state. Asserting reset mid-BUSY or in DONE drops the operation: no v_o pulse, and IDLE on the next cycle.
- Latency, as an iteration count N = max(1, floor(log2(exp))+1):
  - Accept edge at cycle T.
  - BUSY occupies cycles T+1 … T+N.
  - v_o is high from cycle T+N+1.
- Worst case: N = exp_width_p.
- Throughput: the consume edge at cycle D gives IDLE in cycle D+1. The next accept can happen at the end of D+1. With yumi tied high, the minimum spacing between accepts is N+2 cycles.
- Outputs are registered; there are no combinational paths from inputs to ready_o or v_o.

## Test plan
- **3^5, yumi held high.** base=3, exp=5, width_p=32.
  - data_o=243 (0xF3), overflow_o=0.
  - v_o rises exactly 3 cycles after the accept cycle and drops the cycle after yumi.
- **2^31 and 2^32.**
  - base=2, exp=31: data_o=0x8000_0000, overflow_o=0, N=5.
  - base=2, exp=32: data_o=0, overflow_o=1, N=6.
- **Zero exponent and zero base.**
  - base=0, exp=0: data_o=1, overflow_o=0, N=1.
  - base=0, exp=40: data_o=0, overflow_o=0.
  - base=0xFFFF_FFFF, exp=1: data_o=0xFFFF_FFFF, overflow_o=0.
- **Backpressure.**
  - Hold yumi_i=0 for 10 cycles after v_o rises. data_o and overflow_o stay stable, and ready_o stays 0 while v_i is held high.
  - Then yumi for 1 cycle. A second op (7^2) is accepted the next cycle and returns 49.
- **Reset mid-op.** Start base=3, exp=0xFFFF_FFFF and assert reset in the 4th BUSY cycle.
  - Next cycle: ready_o=1, v_o=0, data_o=0.
  - A following 5^3 returns 125 with overflow_o=0.
- **Random sweep vs. reference model.** At least 1000 random base/exp pairs, plus width_p=8, exp_width_p=4 (e.g. 3^6 → 0xD9, overflow_o=1). Check:
  - data_o mod 2^width_p,
  - the overflow flag,
  - per-op latency N.
